// File: rtl/axi_scratch_slave.sv
// AXI4 scratch-memory responder: single outstanding INCR burst, 32-bit beats, flop-based word array.
// Optional AXI_SCRATCH_RANGE_ERR_EN: addresses above the memory window return SLVERR instead of aliasing.
module axi_scratch_slave #(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int DEPTH          = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ID_WIDTH-1:0]   aw_id,
    input  logic [AXI_ADDR_WIDTH-1:0] aw_addr,
    input  logic [7:0]                aw_len,
    input  logic                      aw_valid,
    output logic                      aw_ready,
    input  logic [31:0]               w_data,
    input  logic [3:0]                w_strb,
    input  logic                      w_last,
    input  logic                      w_valid,
    output logic                      w_ready,
    output logic [AXI_ID_WIDTH-1:0]   b_id,
    output logic [1:0]                b_resp,
    output logic                      b_valid,
    input  logic                      b_ready,
    input  logic [AXI_ID_WIDTH-1:0]   ar_id,
    input  logic [AXI_ADDR_WIDTH-1:0] ar_addr,
    input  logic [7:0]                ar_len,
    input  logic                      ar_valid,
    output logic                      ar_ready,
    output logic [AXI_ID_WIDTH-1:0]   r_id,
    output logic [31:0]               r_data,
    output logic [1:0]                r_resp,
    output logic                      r_last,
    output logic                      r_valid,
    input  logic                      r_ready
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

    state_t                    state;
    logic                      wr_first;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [IDX_W-1:0]          idx;
    logic [7:0]                len_q;
    logic [7:0]                cnt;
    logic                      err;
    logic                      oob;
    logic [31:0]               mem [DEPTH];

    logic                      grant_w;
    logic                      grant_r;
    logic                      aw_oob;
    logic                      ar_oob;
    logic                      last_beat;
    logic                      unused_addr_bits;

    assign unused_addr_bits = ^{aw_addr, ar_addr};

`ifdef AXI_SCRATCH_RANGE_ERR_EN
    assign aw_oob = (aw_addr >> (2 + IDX_W)) != '0;
    assign ar_oob = (ar_addr >> (2 + IDX_W)) != '0;
`else
    assign aw_oob = 1'b0;
    assign ar_oob = 1'b0;
`endif

    // On simultaneous requests the pointer decides; a lone request always wins.
    assign grant_w  = !rst && (state == IDLE) && aw_valid && (wr_first || !ar_valid);
    assign grant_r  = !rst && (state == IDLE) && ar_valid && !(aw_valid && wr_first);
    assign aw_ready = grant_w;
    assign ar_ready = grant_r;

    assign last_beat = (cnt == len_q);
    assign w_ready   = (state == WRITE);
    assign b_valid   = (state == WRESP);
    assign r_valid   = (state == READ);
    assign b_id      = id_q;
    assign r_id      = id_q;
    assign b_resp    = (b_valid && (err || oob)) ? 2'b10 : 2'b00;
    assign r_resp    = (r_valid && oob) ? 2'b10 : 2'b00;
    assign r_last    = r_valid && last_beat;
    assign r_data    = !r_valid ? '0 : (oob ? 32'hDEAD_BEEF : mem[idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_first <= 1'b1;
            id_q     <= '0;
            idx      <= '0;
            len_q    <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            oob      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_w) begin
                        state    <= WRITE;
                        wr_first <= !wr_first;
                        id_q     <= aw_id;
                        idx      <= aw_addr[2 +: IDX_W];
                        len_q    <= aw_len;
                        cnt      <= '0;
                        err      <= 1'b0;
                        oob      <= aw_oob;
                    end else if (grant_r) begin
                        state    <= READ;
                        wr_first <= !wr_first;
                        id_q     <= ar_id;
                        idx      <= ar_addr[2 +: IDX_W];
                        len_q    <= ar_len;
                        cnt      <= '0;
                        err      <= 1'b0;
                        oob      <= ar_oob;
                    end
                end
                WRITE: begin
                    if (w_valid) begin
                        idx <= idx + 1'b1;
                        cnt <= cnt + 8'd1;
                        // Burst length comes from aw_len; a misplaced w_last only flags the response.
                        if (w_last != last_beat) err <= 1'b1;
                        if (last_beat) state <= WRESP;
                    end
                end
                WRESP: begin
                    if (b_ready) state <= IDLE;
                end
                READ: begin
                    if (r_ready) begin
                        idx <= idx + 1'b1;
                        cnt <= cnt + 8'd1;
                        if (last_beat) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (!rst && (state == WRITE) && w_valid && !oob) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_strb[i]) mem[idx][8*i +: 8] <= w_data[8*i +: 8];
            end
        end
    end
endmodule

// File: doc/axi_scratch_slave.md
Name: axi_scratch_slave

Overview:
- AXI4 responder that terminates one slave-side port of the AXI node (ID width `AXI_ID_SLAVE_WIDTH`, 32-bit data).
- Backs a small flop-based word memory that cores, the debug unit and the SPI slave can reach as scratch storage and as a bus-test target.
- Serves one transaction at a time. Supports INCR bursts of 32-bit beats only.

Parameters:
- AXI_ID_WIDTH, 4, width of aw_id, b_id, ar_id and r_id
- AXI_ADDR_WIDTH, 32, width of aw_addr and ar_addr
- DEPTH, 256, memory size in 32-bit words; power of two, minimum 2

Ports:
- clk  in  1  clock; everything samples on the rising edge
- rst  in  1  synchronous, active-high reset
- aw_id  in  AXI_ID_WIDTH  write address ID
- aw_addr  in  AXI_ADDR_WIDTH  write start byte address
- aw_len  in  8  write beats minus 1
- aw_valid  in  1  write address valid
- aw_ready  out  1  write address accepted
- w_data  in  32  write data
- w_strb  in  4  byte enables
- w_last  in  1  final write beat
- w_valid  in  1  write data valid
- w_ready  out  1  write data accepted
- b_id  out  AXI_ID_WIDTH  response ID
- b_resp  out  2  write response
- b_valid  out  1  write response valid
- b_ready  in  1  write response taken
- ar_id  in  AXI_ID_WIDTH  read address ID
- ar_addr  in  AXI_ADDR_WIDTH  read start byte address
- ar_len  in  8  read beats minus 1
- ar_valid  in  1  read address valid
- ar_ready  out  1  read address accepted
- r_id  out  AXI_ID_WIDTH  read ID
- r_data  out  32  read data
- r_resp  out  2  read response
- r_last  out  1  final read beat
- r_valid  out  1  read data valid
- r_ready  in  1  read data taken

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high.
- While rst=1 at an edge:
  - State goes to IDLE and the arbitration pointer goes to "write first".
  - All ready/valid outputs are 0; b_resp, r_resp, r_data, r_last, b_id and r_id are 0.
  - Memory contents are retained.
- A reset in the middle of a burst abandons it with no response. The next cycle is IDLE.
- States: IDLE, WRITE, WRESP, READ.
- IDLE:
  - aw_ready and ar_ready are combinational and are asserted only in IDLE.
  - If only one of aw_valid/ar_valid is high, that request is granted.
  - If both are high, grant follows the pointer; the pointer toggles after every grant (round-robin).
  - Only the granted ready goes high. On the handshake, capture id, word index = addr[2 +: log2(DEPTH)] and len.
  - Low address bits [1:0] and bits above the window are ignored.
  - Next state is WRITE or READ.
- WRITE:
  - w_ready=1.
  - Each w handshake writes byte lanes where w_strb[i]=1. Index increments by 1 and wraps modulo DEPTH.
  - Beat counter runs 0..len. The beat with counter==len moves to WRESP, whatever w_last says.
  - Any beat whose w_last differs from (counter==len) sets a sticky error flag for this burst.
- WRESP:
  - b_valid=1, b_id=captured id, b_resp = 2'b10 (SLVERR) if the error flag is set, else 2'b00.
  - b_valid, b_id and b_resp stay stable until b_ready. Return to IDLE on the following edge.
- READ:
  - r_valid=1, r_data = mem[index] (combinational from the array), r_id=captured id, r_resp=00, r_last=(counter==len).
  - r_data, r_id, r_resp and r_last stay stable while r_ready=0.
  - On each handshake the index increments with wrap. After the last handshake, return to IDLE.
- Latency: address handshake in cycle N gives the first w_ready or r_valid in cycle N+1. Max throughput is one beat per cycle.
- Back-to-back transactions take one IDLE cycle between them.

Optional Feature:
- Macro: AXI_SCRATCH_RANGE_ERR_EN.
- When defined, an address with any bit set above the window (addr[AXI_ADDR_WIDTH-1 : 2+log2(DEPTH)] ≠ 0, relative to bit 0):
  - Writes: the whole burst is accepted without modifying memory, and b_resp=SLVERR.
  - Reads: every beat returns r_data=32'hDEAD_BEEF with r_resp=SLVERR.
- When undefined, those upper bits are ignored: addresses alias, data is read or written normally, and the response is OKAY.

Test Plan:
- Reset, then single write: aw_addr=0x10, len=0, w_data=0xA5A5_1234, strb=4'hF → b_resp=00, b_id echoed. Then read at 0x10 → r_data=0xA5A5_1234, r_last=1.
- Byte strobes: write 0xFFFF_FFFF then 0x0000_0000 with strb=4'b0101 to word 3 → read returns 0xFF00_FF00.
- 4-beat INCR write starting at word DEPTH-2 with data 1,2,3,4 → read of words DEPTH-2, DEPTH-1, 0, 1 returns 1,2,3,4; r_last only on beat 4.
- Backpressure and ordering:
  - r_ready low for 3 cycles mid-burst → r_data/r_last stable.
  - aw_valid and ar_valid raised in the same cycle twice in a row → grants are write, then read.
- w_last=1 on beat 2 of a len=3 burst → all 4 beats accepted, b_resp=10.
- Reset asserted mid-read → next cycle r_valid=0; following write/read completes normally. With AXI_SCRATCH_RANGE_ERR_EN, a read at 0x0010_0000 returns 0xDEAD_BEEF with r_resp=10.
